// File: rtl/cv32e40p_tmr_fault_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cv32e40p_tmr_fault_manager: TMR majority voter with replica retirement,   |
// | DMR fallback, saturating error counter and acknowledged alarm. Rev 1.0    |
// +--------------------------------------------------------------------------+
module cv32e40p_tmr_fault_manager #(
  parameter int WIDTH       = 32,
  parameter int PERM_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] in3_i,
  input  logic             clear_i,
  input  logic             alarm_ack_i,
  output logic [WIDTH-1:0] vote_o,
  output logic             fault_o,
  output logic             uncorrectable_o,
  output logic [5:0]       status_o,
  output logic             degraded_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             alarm_o
);

  localparam logic [8:0] C_THRESH = 9'(PERM_THRESH);

  logic [2:0][WIDTH-1:0] in_w;
  logic [WIDTH-1:0]      maj_w;
  logic [WIDTH-1:0]      dmr_a_w;
  logic [WIDTH-1:0]      dmr_b_w;
  logic [2:0]            mism_w;
  logic [2:0]            cross_w;
  logic [2:0][8:0]       inc_w;
  logic                  fault_w;
  logic                  uncorr_w;
  logic                  fail_event_w;
  logic                  alarm_event_w;
  logic [1:0]            fail_idx_w;

  logic [2:0][7:0]       consec_q, consec_d;
  logic [1:0]            failed_idx_q, failed_idx_d;
  logic                  degraded_q, degraded_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic                  alarm_q, alarm_d;

  assign in_w  = {in3_i, in2_i, in1_i};
  assign maj_w = (in1_i & in2_i) | (in1_i & in3_i) | (in2_i & in3_i);

  // Surviving pair in DMR: a is the lower-index healthy replica and drives the vote.
  always_comb begin
    dmr_a_w = in1_i;
    dmr_b_w = in2_i;
    case (failed_idx_q)
      2'd0:    begin dmr_a_w = in2_i; dmr_b_w = in3_i; end
      2'd1:    begin dmr_a_w = in1_i; dmr_b_w = in3_i; end
      default: begin dmr_a_w = in1_i; dmr_b_w = in2_i; end
    endcase
  end

  always_comb begin
    vote_o   = maj_w;
    mism_w   = '0;
    fault_w  = 1'b0;
    uncorr_w = 1'b0;
    if (degraded_q) begin
      vote_o   = dmr_a_w;
      uncorr_w = valid_i & (dmr_a_w != dmr_b_w);
      fault_w  = uncorr_w;
    end else begin
      for (int k = 0; k < 3; k++) begin
        mism_w[k] = (in_w[k] != maj_w);
      end
      fault_w = valid_i & (|mism_w);
    end
  end

  always_comb begin
    consec_d     = consec_q;
    failed_idx_d = failed_idx_q;
    degraded_d   = degraded_q;
    inc_w        = '0;
    cross_w      = '0;
    if (!degraded_q && valid_i) begin
      for (int k = 0; k < 3; k++) begin
        inc_w[k]    = {1'b0, consec_q[k]} + 9'd1;
        consec_d[k] = mism_w[k] ? inc_w[k][7:0] : 8'd0;
        cross_w[k]  = mism_w[k] && (inc_w[k] == C_THRESH);
      end
    end

    // Lowest-index crossing wins; the others lose their history with it.
    fail_idx_w   = cross_w[0] ? 2'd0 : (cross_w[1] ? 2'd1 : 2'd2);
    fail_event_w = (|cross_w) && !clear_i;
    if (fail_event_w) begin
      consec_d     = '0;
      degraded_d   = 1'b1;
      failed_idx_d = fail_idx_w;
    end
    if (clear_i) begin
      consec_d     = '0;
      degraded_d   = 1'b0;
      failed_idx_d = 2'd0;
    end

    alarm_event_w = fail_event_w | uncorr_w;
    if (alarm_event_w) begin
      alarm_d = 1'b1;
    end else if (alarm_ack_i) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end

    err_cnt_d = (fault_w && (err_cnt_q != {CNT_W{1'b1}})) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec_q     <= '0;
      failed_idx_q <= 2'd0;
      degraded_q   <= 1'b0;
      err_cnt_q    <= '0;
      alarm_q      <= 1'b0;
    end else begin
      consec_q     <= consec_d;
      failed_idx_q <= failed_idx_d;
      degraded_q   <= degraded_d;
      err_cnt_q    <= err_cnt_d;
      alarm_q      <= alarm_d;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_status
    assign status_o[2*k+1:2*k] = (degraded_q && (failed_idx_q == 2'(k))) ? 2'b10 :
                                 (consec_q[k] != 8'd0)                   ? 2'b01 : 2'b00;
  end

  assign fault_o         = fault_w;
  assign uncorrectable_o = uncorr_w;
  assign degraded_o      = degraded_q;
  assign err_cnt_o       = err_cnt_q;
  assign alarm_o         = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cv32e40p_tmr_fault_manager: directed + random bench with a reference  |
// | model of the voter/fault manager. Rev 1.0                                 |
// +--------------------------------------------------------------------------+
module tb_cv32e40p_tmr_fault_manager;

  localparam int W  = 32;
  localparam int TH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          alarm_ack_i = 1'b0;
  logic [W-1:0]  in1_i = '0, in2_i = '0, in3_i = '0;

  logic [W-1:0]  vote_o;
  logic          fault_o, uncorrectable_o, degraded_o, alarm_o;
  logic [5:0]    status_o;
  logic [15:0]   err_cnt_o;

  logic [W-1:0]  s_vote;
  logic          s_fault, s_unc, s_deg, s_alarm;
  logic [5:0]    s_status;
  logic [3:0]    s_err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_failed;
  int m_consec[3];
  bit m_alarm;
  int m_err;

  cv32e40p_tmr_fault_manager #(.WIDTH(W), .PERM_THRESH(TH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .in1_i(in1_i), .in2_i(in2_i), .in3_i(in3_i),
    .clear_i(clear_i), .alarm_ack_i(alarm_ack_i), .vote_o(vote_o), .fault_o(fault_o),
    .uncorrectable_o(uncorrectable_o), .status_o(status_o), .degraded_o(degraded_o),
    .err_cnt_o(err_cnt_o), .alarm_o(alarm_o));

  cv32e40p_tmr_fault_manager #(.WIDTH(W), .PERM_THRESH(TH), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .in1_i(in1_i), .in2_i(in2_i), .in3_i(in3_i),
    .clear_i(clear_i), .alarm_ack_i(alarm_ack_i), .vote_o(s_vote), .fault_o(s_fault),
    .uncorrectable_o(s_unc), .status_o(s_status), .degraded_o(s_deg),
    .err_cnt_o(s_err), .alarm_o(s_alarm));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_failed = -1;
    for (int k = 0; k < 3; k++) m_consec[k] = 0;
    m_alarm = 0;
    m_err   = 0;
  endtask

  task automatic ref_comb(output logic [W-1:0] v, output bit f, output bit u, output bit [2:0] mm);
    logic [W-1:0] x[3];
    int h[$];
    x[0] = in1_i; x[1] = in2_i; x[2] = in3_i;
    mm = '0; u = 0; v = '0;
    if (m_failed < 0) begin
      for (int b = 0; b < W; b++) begin
        int ones;
        ones = int'(x[0][b]) + int'(x[1][b]) + int'(x[2][b]);
        v[b] = (ones >= 2);
      end
      for (int k = 0; k < 3; k++) mm[k] = (x[k] != v);
      f = valid_i && (mm != 0);
    end else begin
      for (int k = 0; k < 3; k++) if (k != m_failed) h.push_back(k);
      v = x[h[0]];
      f = valid_i && (x[h[0]] != x[h[1]]);
      u = f;
    end
  endtask

  function automatic logic [5:0] ref_status();
    logic [5:0] s;
    s = '0;
    for (int k = 0; k < 3; k++)
      s[2*k +: 2] = (k == m_failed) ? 2'b10 : (m_consec[k] > 0 ? 2'b01 : 2'b00);
    return s;
  endfunction

  task automatic check_all();
    logic [W-1:0] v; bit f, u; bit [2:0] mm;
    ref_comb(v, f, u, mm);
    check("vote", vote_o, v);
    check("fault", fault_o, f);
    check("uncorrectable", uncorrectable_o, u);
    check("status", status_o, ref_status());
    check("degraded", degraded_o, (m_failed >= 0));
    check("err_cnt", err_cnt_o, (m_err > 65535) ? 65535 : m_err);
    check("err_cnt_small", s_err, (m_err > 15) ? 15 : m_err);
    check("alarm", alarm_o, m_alarm);
  endtask

  task automatic model_update();
    logic [W-1:0] v; bit f, u; bit [2:0] mm;
    bit event_hit;
    int first;
    ref_comb(v, f, u, mm);
    event_hit = 0;
    first = -1;
    if (m_failed < 0 && valid_i) begin
      for (int k = 0; k < 3; k++) begin
        m_consec[k] = mm[k] ? m_consec[k] + 1 : 0;
        if (m_consec[k] == TH && first < 0) first = k;
      end
      if (first >= 0 && !clear_i) begin
        m_failed = first;
        for (int k = 0; k < 3; k++) m_consec[k] = 0;
        event_hit = 1;
      end
    end
    if (u) event_hit = 1;
    if (clear_i) begin
      m_failed = -1;
      for (int k = 0; k < 3; k++) m_consec[k] = 0;
    end
    if (f) m_err++;
    if (event_hit) m_alarm = 1;
    else if (alarm_ack_i) m_alarm = 0;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input bit clr, input bit ack);
    valid_i = v; in1_i = a; in2_i = b; in3_i = c; clear_i = clr; alarm_ack_i = ack;
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [W-1:0] base;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    check("reset_status", status_o, 6'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // equal inputs
    drive(1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 0, 0);
    repeat (10) step();
    check("eq_vote", vote_o, 32'h1234_5678);
    check("eq_err", err_cnt_o, 16'd0);

    // transient replica 1 fault
    drive(1, 32'h1234_5678, 32'h1234_5679, 32'h1234_5678, 0, 0);
    repeat (3) step();
    check("suspect_status", status_o[3:2], 2'b01);
    drive(1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 0, 0);
    step();
    check("transient_status", status_o, 6'd0);
    check("transient_err", err_cnt_o, 16'd3);
    check("transient_alarm", alarm_o, 1'b0);

    // replica 2 persistent fault with a valid gap
    drive(1, 32'hA, 32'hA, 32'h5, 0, 0);
    repeat (2) step();
    drive(0, 32'hA, 32'hA, 32'h5, 0, 0);
    repeat (2) step();
    drive(1, 32'hA, 32'hA, 32'h5, 0, 0);
    repeat (2) step();
    check("fail2_status", status_o, 6'b10_00_00);
    check("fail2_degraded", degraded_o, 1'b1);
    check("fail2_alarm", alarm_o, 1'b1);
    drive(1, 32'hA, 32'hA, 32'h7, 0, 1);
    step();
    check("ack_alarm", alarm_o, 1'b0);

    // DMR mismatch with failed replica 2
    drive(1, 32'hA, 32'hB, 32'hA, 0, 0);
    @(negedge clk);
    check("dmr_vote", vote_o, 32'hA);
    check("dmr_unc", uncorrectable_o, 1'b1);
    @(posedge clk); model_update(); #1;
    check("dmr_alarm", alarm_o, 1'b1);

    // clear, then pairwise-different inputs
    drive(1, 32'h1, 32'h1, 32'h1, 1, 1);
    step();
    drive(1, 32'h1, 32'h2, 32'h4, 0, 0);
    repeat (4) step();
    check("pairwise_status", status_o, 6'b00_00_10);
    check("pairwise_alarm", alarm_o, 1'b1);

    // clear in the threshold cycle
    drive(1, 32'h1, 32'h1, 32'h1, 1, 1);
    step();
    drive(1, 32'h1, 32'h3, 32'h1, 0, 0);
    repeat (3) step();
    drive(1, 32'h1, 32'h3, 32'h1, 1, 0);
    step();
    check("clear_thresh_degraded", degraded_o, 1'b0);
    check("clear_thresh_status", status_o, 6'd0);

    // saturation of the small counter: 4 TMR faults, then 16 DMR faults
    drive(1, 32'h1, 32'h1, 32'h1, 0, 0);
    step();
    drive(1, 32'h1, 32'h1, 32'h9, 0, 0);
    repeat (4) step();
    drive(1, 32'h1, 32'h2, 32'h9, 0, 0);
    repeat (16) step();
    check("sat_small", s_err, 4'hF);

    // asynchronous reset in DMR
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_degraded", degraded_o, 1'b0);
    check("arst_status", status_o, 6'd0);
    check("arst_err", err_cnt_o, 16'd0);
    check("arst_alarm", alarm_o, 1'b0);
    check("arst_unc", uncorrectable_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random phase
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] a, b, c;
      base = $urandom;
      a = base; b = base; c = base;
      if ($urandom_range(0, 99) < 20) a = base ^ (W'(1) << $urandom_range(0, W-1));
      if ($urandom_range(0, 99) < 20) b = base ^ (W'(1) << $urandom_range(0, W-1));
      if ($urandom_range(0, 99) < 20) c = base ^ (W'(1) << $urandom_range(0, W-1));
      drive($urandom_range(0, 99) < 80, a, b, c,
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 20);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
